// File: rtl/axi_ch_pkg.sv
// Shared defaults and width helper for the AXI channel read buffer.
package axi_ch_pkg;

  localparam int unsigned AXI_CH_WIDTH_DEF = 8;
  localparam int unsigned AXI_CH_DEPTH_DEF = 4;

  // Ceiling log2, used for pointer, count and gap-counter widths.
  function automatic int unsigned axi_ch_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_ch_fifo_mem.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Storage is not reset; only the read register is.
module axi_ch_fifo_mem
  import axi_ch_pkg::*;
#(
  parameter int unsigned WIDTH = AXI_CH_WIDTH_DEF,
  parameter int unsigned DEPTH = AXI_CH_DEPTH_DEF,
  localparam int unsigned AW = axi_ch_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             anreset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when not reading.
  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_ch_read_buf.sv
// Buffered channel read block: accepts words on valid/ready, replays each
// downstream as a one-cycle cs strobe with the word on q, honouring stall
// and a minimum gap between strobes.
module axi_ch_read_buf
  import axi_ch_pkg::*;
#(
  parameter int unsigned WIDTH   = AXI_CH_WIDTH_DEF,
  parameter int unsigned DEPTH   = AXI_CH_DEPTH_DEF,
  parameter int unsigned MIN_GAP = 0,
  localparam int unsigned AW = axi_ch_clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             anreset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  input  logic             stall,
  output logic             cs,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    count
);

  localparam int unsigned GW = (MIN_GAP == 0) ? 1 : axi_ch_clog2(MIN_GAP + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          push;
  logic          pop;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [GW-1:0] gap_cnt;
  logic [CW-1:0] count_nxt;

  // Pop uses only registered state, so a word pushed at one edge is
  // first eligible for issue at the following edge.
  assign push = valid && ready;
  assign pop  = (count != '0) && !stall && (gap_cnt == '0);

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // Occupancy and ready; ready tracks the next occupancy so it drops the
  // same edge the last slot fills and rises the same edge a slot frees.
  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      count <= '0;
      ready <= 1'b0;
    end else begin
      count <= count_nxt;
      ready <= (count_nxt != FULL);
    end
  end

  // Read/write pointers; power-of-two depth lets them wrap naturally.
  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // Strobe and minimum-gap counter; the counter runs down even while stalled.
  always_ff @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      cs      <= 1'b0;
      gap_cnt <= '0;
    end else begin
      cs <= pop;
      if (pop)                 gap_cnt <= GW'(MIN_GAP);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);
    end
  end

  axi_ch_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .anreset (anreset),
    .we      (push),
    .waddr   (wptr),
    .wdata   (data),
    .re      (pop),
    .raddr   (rptr),
    .rdata   (q)
  );

endmodule

// File: tb/tb_axi_ch_read_buf.sv
// Bench for axi_ch_read_buf: two instances (MIN_GAP=0 and MIN_GAP=2), a
// cycle model plus an in-order scoreboard of accepted words.
module tb_axi_ch_read_buf;

  logic            clk = 1'b0;
  logic            anreset;
  logic [1:0]      v, s, rdy, csv;
  logic [1:0][7:0] d, qv;
  logic [1:0][2:0] cnt;

  always #5 clk = ~clk;

  axi_ch_read_buf #(.WIDTH(8), .DEPTH(4), .MIN_GAP(0)) u_buf0 (
    .clk(clk), .anreset(anreset), .valid(v[0]), .data(d[0]), .ready(rdy[0]),
    .stall(s[0]), .cs(csv[0]), .q(qv[0]), .count(cnt[0])
  );

  axi_ch_read_buf #(.WIDTH(8), .DEPTH(4), .MIN_GAP(2)) u_buf2 (
    .clk(clk), .anreset(anreset), .valid(v[1]), .data(d[1]), .ready(rdy[1]),
    .stall(s[1]), .cs(csv[1]), .q(qv[1]), .count(cnt[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Cycle model state
  int         m_cnt [2];
  int         m_gap [2];
  int         m_hd  [2];
  int         m_tl  [2];
  bit         m_rdy [2];
  bit         m_cs  [2];
  logic [7:0] m_q   [2];
  logic [7:0] m_mem [2][4];
  int         gap_cfg [2] = '{0, 2};

  // Scoreboards of accepted words, one per instance
  logic [7:0] sb0 [$];
  logic [7:0] sb1 [$];

  always @(posedge clk or negedge anreset) begin
    if (!anreset) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_gap[k] = 0; m_hd[k] = 0; m_tl[k] = 0;
        m_rdy[k] = 0; m_cs[k] = 0; m_q[k] = '0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit pu, po;
        po = (m_cnt[k] != 0) && !s[k] && (m_gap[k] == 0);
        pu = v[k] && m_rdy[k];
        if (po) begin
          m_q[k]  = m_mem[k][m_hd[k]];
          m_hd[k] = (m_hd[k] + 1) % 4;
          m_cs[k] = 1;
          m_gap[k] = gap_cfg[k];
        end else begin
          m_cs[k] = 0;
          if (m_gap[k] > 0) m_gap[k]--;
        end
        if (pu) begin
          m_mem[k][m_tl[k]] = d[k];
          m_tl[k] = (m_tl[k] + 1) % 4;
          if (k == 0) sb0.push_back(d[k]);
          else        sb1.push_back(d[k]);
        end
        m_cnt[k] = m_cnt[k] + int'(pu) - int'(po);
        m_rdy[k] = (m_cnt[k] < 4);
      end
    end
  end

  // Monitor: compare every cycle on the falling edge, pop scoreboard on cs
  int cyc = 0;
  int cs_n [2] = '{0, 0};
  int cs_t2 [$];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready%0d", k), rdy[k], m_rdy[k]);
      chk($sformatf("cs%0d", k),    csv[k], m_cs[k]);
      chk($sformatf("count%0d", k), cnt[k], m_cnt[k]);
      chk($sformatf("q%0d", k),     qv[k],  m_q[k]);
      if (csv[k] === 1'b1) begin
        cs_n[k]++;
        if (k == 0) begin
          chk("sb0_avail", 32'(sb0.size() > 0), 1);
          if (sb0.size() > 0) chk("sb0_order", qv[0], sb0.pop_front());
        end else begin
          cs_t2.push_back(cyc);
          chk("sb1_avail", 32'(sb1.size() > 0), 1);
          if (sb1.size() > 0) chk("sb1_order", qv[1], sb1.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    anreset = 1'b0;
    v = '0; s = '0; d = '0;
    tick(2);
    chk("rst_ready", rdy[0], 0);
    chk("rst_cs",    csv[0], 0);
    chk("rst_q",     qv[0],  0);
    chk("rst_count", cnt[0], 0);
    anreset = 1'b1;
    tick();
    chk("ready_after_rst", rdy[0], 1);

    // Single pulse
    d[0] = 8'hA5; v[0] = 1'b1;
    tick();
    v[0] = 1'b0;
    chk("single_cnt1", cnt[0], 1);
    tick();
    chk("single_cs",   csv[0], 1);
    chk("single_q",    qv[0],  8'hA5);
    chk("single_cnt0", cnt[0], 0);
    tick(3);

    // Sustained back-to-back words
    for (int i = 1; i <= 3; i++) begin
      d[0] = 8'(i); v[0] = 1'b1;
      tick();
    end
    v[0] = 1'b0;
    tick(5);

    // Fill while stalled; fifth word must be refused
    s[0] = 1'b1; v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d[0] = 8'h10 + 8'(i);
      tick();
    end
    v[0] = 1'b0;
    chk("full_cnt",   cnt[0], 4);
    chk("full_ready", rdy[0], 0);
    s[0] = 1'b0;
    tick();
    chk("first_pop_cs",    csv[0], 1);
    chk("first_pop_q",     qv[0],  8'h10);
    chk("ready_after_pop", rdy[0], 1);
    tick(6);

    // Two words with stall toggling every cycle
    for (int i = 0; i < 12; i++) begin
      s[0] = i[0];
      v[0] = (i == 0 || i == 2);
      d[0] = (i == 0) ? 8'h21 : 8'h22;
      tick();
    end
    s[0] = 1'b0; v[0] = 1'b0;
    tick(3);

    // Reset mid-stream with three words buffered
    s[0] = 1'b1; v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[0] = 8'h30 + 8'(i);
      tick();
    end
    v[0] = 1'b0;
    chk("pre_rst_cnt", cnt[0], 3);
    #2 anreset = 1'b0;
    #1;
    chk("mid_rst_cs",    csv[0], 0);
    chk("mid_rst_ready", rdy[0], 0);
    chk("mid_rst_count", cnt[0], 0);
    chk("mid_rst_q",     qv[0],  0);
    tick();
    anreset = 1'b1;
    s[0] = 1'b0;
    tick(6);

    // MIN_GAP=2 instance: three consecutive pushes
    v[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[1] = 8'h40 + 8'(i);
      tick();
    end
    v[1] = 1'b0;
    tick(12);

    chk("cs0_total", cs_n[0], 10);
    chk("cs2_total", cs_n[1], 3);
    chk("sb0_left",  sb0.size(), 0);
    chk("sb1_left",  sb1.size(), 0);
    chk("cs2_times", cs_t2.size(), 3);
    if (cs_t2.size() == 3) begin
      chk("gap2_a", cs_t2[1] - cs_t2[0], 3);
      chk("gap2_b", cs_t2[2] - cs_t2[1], 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
